// File: rtl/frame_loader.sv
// frame_loader: moves one decoded instruction at a time into the execute frame.
// Sequence per instruction: accept (control fields + register-file read),
// operand capture, then frame held valid until execute consumes it.
// A load followed by a dependent instruction inserts a one-cycle stall;
// flush from execute cancels whatever is in flight.
// Optional feature: define STALL_COUNT_EN to add the 32-bit stallCount output.

`ifndef REGADDR_WIDTH
`define REGADDR_WIDTH 5
`endif

module frame_loader (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      decValid,
  output logic                      decReady,
  input  logic [`REGADDR_WIDTH-1:0] aLoc_in,
  input  logic [`REGADDR_WIDTH-1:0] bLoc_in,
  input  logic [`REGADDR_WIDTH-1:0] writeSelect_in,
  input  logic                      usesA,
  input  logic                      usesB,
  input  logic                      load_in,
  output logic                      rfReadEn,
  output logic [`REGADDR_WIDTH-1:0] rfAddrA,
  output logic [`REGADDR_WIDTH-1:0] rfAddrB,
  output logic                      ctrl_we,
  output logic                      opA_we,
  output logic                      opB_we,
  output logic                      bubble,
  output logic                      frameValid,
  input  logic                      exeReady,
  input  logic                      flush
`ifdef STALL_COUNT_EN
  ,
  output logic [31:0]               stallCount
`endif
);

  localparam int AW = `REGADDR_WIDTH;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    VALID = 2'd2,
    STALL = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic            frame_valid_q, frame_valid_d;
  logic            last_load_q, last_load_d;
  logic [AW-1:0]   last_dest_q, last_dest_d;
  logic            uses_a_q, uses_a_d;
  logic            uses_b_q, uses_b_d;
  logic            load_q, load_d;
  logic [AW-1:0]   write_select_q, write_select_d;
`ifdef STALL_COUNT_EN
  logic [31:0]     stall_count_q, stall_count_d;
`endif

  logic            hazard;

  // Load-use hazard: the consumed load's destination is read by the incoming instruction.
  assign hazard = last_load_q && (last_dest_q != '0) &&
                  ((usesA && (aLoc_in == last_dest_q)) ||
                   (usesB && (bLoc_in == last_dest_q)));

  // Read addresses follow the decoder directly so data returns the cycle after acceptance.
  assign rfAddrA = aLoc_in;
  assign rfAddrB = bLoc_in;

  assign frameValid = frame_valid_q;
`ifdef STALL_COUNT_EN
  assign stallCount = stall_count_q;
`endif

  // Next-state, captured fields and same-cycle strobes; flush outranks everything.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path leaves one unassigned and no latch is inferred.
    state_d        = state_q;
    frame_valid_d  = frame_valid_q;
    last_load_d    = last_load_q;
    last_dest_d    = last_dest_q;
    uses_a_d       = uses_a_q;
    uses_b_d       = uses_b_q;
    load_d         = load_q;
    write_select_d = write_select_q;
`ifdef STALL_COUNT_EN
    stall_count_d  = stall_count_q;
`endif
    decReady = 1'b0;
    rfReadEn = 1'b0;
    ctrl_we  = 1'b0;
    opA_we   = 1'b0;
    opB_we   = 1'b0;
    bubble   = 1'b0;

    // While reset is high the strobes stay low; the flops are held by the async reset.
    if (!reset) begin
      if (flush) begin
        bubble        = 1'b1;
        state_d       = IDLE;
        frame_valid_d = 1'b0;
        last_load_d   = 1'b0;
      end else begin
        unique case (state_q)
          IDLE: begin
            decReady = !hazard;
            if (decValid && hazard) begin
              bubble      = 1'b1;
              state_d     = STALL;
              last_load_d = 1'b0;
`ifdef STALL_COUNT_EN
              stall_count_d = stall_count_q + 32'd1;
`endif
            end else if (decValid) begin
              ctrl_we        = 1'b1;
              rfReadEn       = 1'b1;
              uses_a_d       = usesA;
              uses_b_d       = usesB;
              load_d         = load_in;
              write_select_d = writeSelect_in;
              state_d        = READ;
            end
          end
          READ: begin
            opA_we        = uses_a_q;
            opB_we        = uses_b_q;
            state_d       = VALID;
            frame_valid_d = 1'b1;
          end
          VALID: begin
            if (exeReady) begin
              last_load_d   = load_q;
              last_dest_d   = write_select_q;
              state_d       = IDLE;
              frame_valid_d = 1'b0;
            end
          end
          STALL: begin
            state_d = IDLE;
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end

  // State and captured fields; asynchronous reset discards any instruction in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      frame_valid_q  <= 1'b0;
      last_load_q    <= 1'b0;
      last_dest_q    <= '0;
      uses_a_q       <= 1'b0;
      uses_b_q       <= 1'b0;
      load_q         <= 1'b0;
      write_select_q <= '0;
`ifdef STALL_COUNT_EN
      stall_count_q  <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
      state_q        <= state_d;
      frame_valid_q  <= frame_valid_d;
      last_load_q    <= last_load_d;
      last_dest_q    <= last_dest_d;
      uses_a_q       <= uses_a_d;
      uses_b_q       <= uses_b_d;
      load_q         <= load_d;
      write_select_q <= write_select_d;
`ifdef STALL_COUNT_EN
      stall_count_q  <= stall_count_d;
`endif
    end
  end

endmodule

// File: tb/tb_frame_loader.sv
// tb_frame_loader: directed scenarios followed by random traffic, every cycle
// compared with a transaction-level model of the frame loader.

`ifndef REGADDR_WIDTH
`define REGADDR_WIDTH 5
`endif

module tb_frame_loader;

  localparam int AW = `REGADDR_WIDTH;

  logic          clk = 1'b0;
  logic          reset;
  logic          decValid;
  logic          decReady;
  logic [AW-1:0] aLoc_in, bLoc_in, writeSelect_in;
  logic          usesA, usesB, load_in;
  logic          rfReadEn;
  logic [AW-1:0] rfAddrA, rfAddrB;
  logic          ctrl_we, opA_we, opB_we, bubble;
  logic          frameValid;
  logic          exeReady;
  logic          flush;
`ifdef STALL_COUNT_EN
  logic [31:0]   stallCount;
`endif

  frame_loader dut (
    .clk           (clk),
    .reset         (reset),
    .decValid      (decValid),
    .decReady      (decReady),
    .aLoc_in       (aLoc_in),
    .bLoc_in       (bLoc_in),
    .writeSelect_in(writeSelect_in),
    .usesA         (usesA),
    .usesB         (usesB),
    .load_in       (load_in),
    .rfReadEn      (rfReadEn),
    .rfAddrA       (rfAddrA),
    .rfAddrB       (rfAddrB),
    .ctrl_we       (ctrl_we),
    .opA_we        (opA_we),
    .opB_we        (opB_we),
    .bubble        (bubble),
    .frameValid    (frameValid),
    .exeReady      (exeReady),
    .flush         (flush)
`ifdef STALL_COUNT_EN
    ,
    .stallCount    (stallCount)
`endif
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  // Transaction-level model: age of the in-flight instruction
  // (0 none, 1 operands arriving, 2 waiting in frame), pending stall,
  // the last consumed instruction, and a stall tally.
  int            m_age;
  bit            m_stall;
  bit            m_last_load;
  logic [AW-1:0] m_last_dest;
  bit            m_ua, m_ub, m_ld;
  logic [AW-1:0] m_ws;
  logic [31:0]   m_stalls;
  bit            m_hz;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_age = 0; m_stall = 0; m_last_load = 0; m_last_dest = '0;
    m_ua = 0; m_ub = 0; m_ld = 0; m_ws = '0; m_stalls = '0; m_hz = 0;
  endtask

  // Called just after a falling edge with inputs set: compare all outputs with the model.
  task automatic settle();
    bit e_dr, e_rf, e_cw, e_oa, e_ob, e_bub, e_fv;
    #1;
    if (reset) model_clear();
    e_dr = 0; e_rf = 0; e_cw = 0; e_oa = 0; e_ob = 0; e_bub = 0;
    e_fv = (m_age == 2);
    m_hz = m_last_load && (m_last_dest != 0) &&
           ((usesA && aLoc_in == m_last_dest) || (usesB && bLoc_in == m_last_dest));
    if (!reset) begin
      if (flush) e_bub = 1;
      else if (m_stall) ;
      else if (m_age == 1) begin e_oa = m_ua; e_ob = m_ub; end
      else if (m_age == 0) begin
        e_dr = !m_hz;
        if (decValid) begin
          if (m_hz) e_bub = 1;
          else begin e_cw = 1; e_rf = 1; end
        end
      end
    end
    check("decReady",   decReady,   e_dr);
    check("rfReadEn",   rfReadEn,   e_rf);
    check("ctrl_we",    ctrl_we,    e_cw);
    check("opA_we",     opA_we,     e_oa);
    check("opB_we",     opB_we,     e_ob);
    check("bubble",     bubble,     e_bub);
    check("frameValid", frameValid, e_fv);
    if (e_rf) begin
      check("rfAddrA", rfAddrA, aLoc_in);
      check("rfAddrB", rfAddrB, bLoc_in);
    end
`ifdef STALL_COUNT_EN
    check("stallCount", stallCount, m_stalls);
`endif
  endtask

  // Clock edge, model update with the inputs that were presented, back to the falling edge.
  task automatic advance();
    @(posedge clk);
    if (!reset) begin
      if (flush) begin
        m_age = 0; m_stall = 0; m_last_load = 0;
      end else if (m_stall) m_stall = 0;
      else if (m_age == 1) m_age = 2;
      else if (m_age == 2) begin
        if (exeReady) begin
          m_last_load = m_ld; m_last_dest = m_ws; m_age = 0;
        end
      end else if (decValid) begin
        if (m_hz) begin
          m_stall = 1; m_last_load = 0; m_stalls = m_stalls + 1;
        end else begin
          m_ua = usesA; m_ub = usesB; m_ld = load_in; m_ws = writeSelect_in; m_age = 1;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic cycle();
    settle();
    advance();
  endtask

  task automatic drain();
    decValid = 0; exeReady = 1;
    repeat (3) cycle();
    exeReady = 0;
  endtask

  task automatic present(input logic [AW-1:0] a, input logic [AW-1:0] b, input logic [AW-1:0] ws,
                         input bit ua, input bit ub, input bit ld);
    decValid = 1; aLoc_in = a; bLoc_in = b; writeSelect_in = ws;
    usesA = ua; usesB = ub; load_in = ld;
  endtask

  // A load to dest is consumed, then an instruction reading dest is presented.
  task automatic load_then_use(input logic [AW-1:0] dest, input bit use_b, input bit exp_stall);
    present('0, '0, dest, 0, 0, 1);
    cycle();
    drain();
    present(dest, dest, 1, !use_b, use_b, 0);
    settle();
    if (exp_stall) begin
      check("hz_decReady", decReady, 0);
      check("hz_bubble", bubble, 1);
      advance();
      settle();
      check("stall_decReady", decReady, 0);
      check("stall_bubble", bubble, 0);
      advance();
      settle();
      check("after_stall_ctrl_we", ctrl_we, 1);
      advance();
    end else begin
      check("nohz_decReady", decReady, 1);
      check("nohz_ctrl_we", ctrl_we, 1);
      advance();
    end
    drain();
  endtask

  initial begin
    reset = 1; decValid = 0; aLoc_in = '0; bLoc_in = '0; writeSelect_in = '0;
    usesA = 0; usesB = 0; load_in = 0; exeReady = 0; flush = 0;
    model_clear();
    @(negedge clk);
    cycle();
    check("rst_frameValid", frameValid, 0);
    check("rst_decReady", decReady, 0);
    reset = 0;

    // Basic accept: control write and read at cycle 0, operand at 1, frame valid at 2.
    present(3, 0, 1, 1, 0, 0);
    settle();
    check("c0_ctrl_we", ctrl_we, 1);
    check("c0_rfAddrA", rfAddrA, 3);
    advance();
    decValid = 0;
    settle();
    check("c1_opA_we", opA_we, 1);
    advance();
    settle();
    check("c2_frameValid", frameValid, 1);
    advance();

    // Execute back-pressure: frame holds with no write enables.
    repeat (3) begin
      settle();
      check("hold_frameValid", frameValid, 1);
      check("hold_we", {ctrl_we, opA_we, opB_we, bubble}, 0);
      advance();
    end
    exeReady = 1;
    settle();
    advance();
    exeReady = 0;
    settle();
    check("consumed_frameValid", frameValid, 0);
    check("consumed_decReady", decReady, 1);
    advance();

    // Load-use hazard stalls once; load to register 0 does not.
    load_then_use(5, 1, 1);
    load_then_use(0, 1, 0);

    // Flush during operand read cancels the instruction.
    present(1, 2, 3, 1, 1, 0);
    cycle();
    decValid = 0; flush = 1;
    settle();
    check("flush_opA_we", opA_we, 0);
    check("flush_opB_we", opB_we, 0);
    check("flush_bubble", bubble, 1);
    advance();
    flush = 0;
    repeat (3) begin
      settle();
      check("flush_frameValid", frameValid, 0);
      advance();
    end

    // Fresh reset, three hazard stalls, then reset while the frame is valid.
    reset = 1;
    cycle();
    reset = 0;
    load_then_use(5, 1, 1);
    load_then_use(4, 0, 1);
    load_then_use(7, 1, 1);
`ifdef STALL_COUNT_EN
    settle();
    check("three_stalls", stallCount, 3);
    advance();
`endif
    present(2, 2, 2, 1, 1, 0);
    cycle();
    decValid = 0;
    cycle();
    settle();
    check("pre_rst_frameValid", frameValid, 1);
    reset = 1;
    #1;
    check("midrst_frameValid", frameValid, 0);
`ifdef STALL_COUNT_EN
    check("midrst_stallCount", stallCount, 0);
`endif
    model_clear();
    @(negedge clk);
    cycle();
    reset = 0;
    repeat (3) cycle();

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      decValid       = ($urandom_range(0, 3) != 0);
      aLoc_in        = AW'($urandom_range(0, 3));
      bLoc_in        = AW'($urandom_range(0, 3));
      writeSelect_in = AW'($urandom_range(0, 3));
      usesA          = $urandom_range(0, 1) != 0;
      usesB          = $urandom_range(0, 1) != 0;
      load_in        = $urandom_range(0, 1) != 0;
      exeReady       = ($urandom_range(0, 2) != 0);
      flush          = ($urandom_range(0, 11) == 0);
      reset          = ($urandom_range(0, 99) == 0);
      cycle();
    end
    reset = 0; flush = 0; decValid = 0;
    cycle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
